data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 20 ++
 rtl/data_mem_responder_dmem_ram.sv | 35 +++
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
//   mem_size_t       : access size encoding on req_size
//   resp_state_t     : responder FSM state
//   DMEM_DEPTH_WORDS : default RAM depth in 32-bit words
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mem_size_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } resp_state_t;

  localparam int DMEM_DEPTH_WORDS = 1024;

endpackage

// File: rtl/data_mem_responder_dmem_ram.sv
// dmem_ram: single-port word RAM.
// Writes use per-byte enables. Reads are synchronous and update only when
// re is high, so the output holds between reads. Data is never reset.
//   clk   : clock
//   we    : write strobe (qualified by be)
//   re    : read strobe, captures mem[addr] into rdata
//   addr  : word index
//   be    : byte write enables, bit i covers wdata[8*i+7:8*i]
//   wdata : write data, already lane-replicated by the caller
//   rdata : registered read data
module dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store per cycle on a valid/ready
// request channel and returns one response per request on a valid/ready
// response channel. Misaligned, oversize or out-of-range accesses fault
// without touching RAM.
//   clk, rst       : clock, async active-high reset
//   req_*          : request channel (valid/ready, we, byte addr, size,
//                    unsigned-load flag, right-aligned store data)
//   resp_*         : response channel (valid/ready, load data, error)
//
// state   | meaning
// IDLE    | no response pending, resp_valid=0
// RESP    | response held on resp_* until consumed
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  resp_state_t state_q, state_d;
  logic        accept, consume;
  logic        err_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;

  logic        err_q, load_q, uns_q;
  mem_size_t   size_q;
  logic [1:0]  lane_q;
  logic [31:0] fmt_c;

  assign resp_valid = (state_q == ST_RESP);
  assign req_ready  = !resp_valid || resp_ready;
  assign accept     = req_valid && req_ready;
  assign consume    = resp_valid && resp_ready;

  always_comb begin
    err_c   = 1'b0;
    be_c    = 4'b0000;
    wdata_c = req_wdata;
    case (req_size)
      SIZE_B: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      SIZE_H: begin
        err_c   = req_addr[0];
        be_c    = 4'b0011 << {req_addr[1], 1'b0};
        wdata_c = {2{req_wdata[15:0]}};
      end
      SIZE_W: begin
        err_c = (req_addr[1:0] != 2'b00);
        be_c  = 4'b1111;
      end
      default: err_c = 1'b1;
    endcase
    if (req_addr[31:2] >= 30'(DEPTH_WORDS)) err_c = 1'b1;
  end

  // Reset gates the write so a store presented on a reset edge is dropped.
  assign ram_we = accept && req_we && !err_c && !rst;
  assign ram_re = accept && !req_we && !err_c;

  dmem_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (req_addr[AW+1:2]),
    .be    (be_c),
    .wdata (wdata_c),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RESP;
      ST_RESP: if (consume && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SIZE_B;
      lane_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q  <= err_c;
        load_q <= !req_we && !err_c;
        uns_q  <= req_unsigned;
        size_q <= err_c ? SIZE_B : mem_size_t'(req_size);
        lane_q <= req_addr[1:0];
      end
    end
  end

  // ram_rdata only changes on an accepted load, so the formatted result
  // stays stable while the response is back-pressured.
  always_comb begin
    fmt_c = ram_rdata;
    case (size_q)
      SIZE_B: begin
        fmt_c[7:0]  = ram_rdata[{lane_q, 3'b000} +: 8];
        fmt_c[31:8] = {24{!uns_q && fmt_c[7]}};
      end
      SIZE_H: begin
        fmt_c[15:0]  = ram_rdata[{lane_q[1], 4'b0000} +: 16];
        fmt_c[31:16] = {16{!uns_q && fmt_c[15]}};
      end
      default: fmt_c = ram_rdata;
    endcase
  end

  assign resp_rdata = load_q ? fmt_c : 32'h0;
  assign resp_err   = err_q;

endmodule
